// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter that owns the select lines of a shared 4:1 mux and
// registers the selected requester's data with a bounded burst per grant.

module rr_mux4_arbiter #(
    parameter int DATA_W    = 1,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    output logic [3:0]        gnt,
    output logic              sel1,
    output logic              sel0,
    output logic [DATA_W-1:0] out,
    output logic              out_valid
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam logic [3:0] CNT_LAST = 4'(BURST_MAX - 1);

    // First set bit of vec scanning start, start+1, ... (mod 4); MSB = found.
    function automatic logic [2:0] rr_pick(input logic [3:0] vec, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (vec[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    state_e            state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [3:0]        gnt_q, gnt_d;
    logic [1:0]        sel_q, sel_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic [2:0]        pick_s;
    logic [DATA_W-1:0] mux_s;

    // State, owner, burst counter and priority pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= 2'd0;
            cnt_q   <= 4'd0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state: hold, hand over without a bubble, re-grant, or go idle.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        pick_s  = 3'b000;
        case (state_q)
            ST_IDLE: begin
                pick_s = rr_pick(req, ptr_q);
                if (pick_s[2]) begin
                    state_d = ST_GRANT;
                    owner_d = pick_s[1:0];
                    cnt_d   = 4'd0;
                    ptr_d   = pick_s[1:0] + 2'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // The owner is excluded so a handover always favours someone else.
                pick_s = rr_pick(req & ~(4'b0001 << owner_q), owner_q + 2'd1);
                if (req[owner_q] && (cnt_q < CNT_LAST)) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (pick_s[2]) begin
                    owner_d = pick_s[1:0];
                    cnt_d   = 4'd0;
                    ptr_d   = pick_s[1:0] + 2'd1;
                end else if (req[owner_q]) begin
                    cnt_d = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: grant/select follow the next owner, data follows the current one.
    always_comb begin
        case (owner_q)
            2'd0:    mux_s = in0;
            2'd1:    mux_s = in1;
            2'd2:    mux_s = in2;
            2'd3:    mux_s = in3;
            default: mux_s = in0;
        endcase
        if (state_d == ST_GRANT) begin
            gnt_d = 4'b0001 << owner_d;
            sel_d = owner_d;
        end else begin
            gnt_d = 4'b0000;
            sel_d = sel_q;
        end
        if (state_q == ST_GRANT) begin
            out_d       = mux_s;
            out_valid_d = 1'b1;
        end else begin
            out_d       = out_q;
            out_valid_d = 1'b0;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= 4'b0000;
            sel_q       <= 2'b00;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel1      = sel_q[1];
    assign sel0      = sel_q[0];
    assign out       = out_q;
    assign out_valid = out_valid_q;

    rr_mux4_arbiter_chk #(.BURST_MAX(BURST_MAX)) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt_q),
        .sel1  (sel_q[1]),
        .sel0  (sel_q[0])
    );

endmodule

// Invariant checker: grant shape, select encoding and bounded waiting.
module rr_mux4_arbiter_chk #(
    parameter int BURST_MAX = 4
) (
    input logic       clk,
    input logic       rst_n,
    input logic [3:0] req,
    input logic [3:0] gnt,
    input logic       sel1,
    input logic       sel0
);

    // Wait counts include the edge that finally grants, hence the +1 bound.
    localparam logic [6:0] WAIT_LIMIT = 7'(3 * BURST_MAX + 1);

    logic [6:0] wait_q [4];

    // Per-requester count of edges spent requesting without the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                wait_q[k] <= 7'd0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (req[k] && !gnt[k] && (wait_q[k] != 7'h7f)) begin
                    wait_q[k] <= wait_q[k] + 7'd1;
                end else if (req[k] && !gnt[k]) begin
                    wait_q[k] <= wait_q[k];
                end else begin
                    wait_q[k] <= 7'd0;
                end
            end
        end
    end

    // Invariants sampled on every active edge outside reset.
    always @(posedge clk) begin
        if (rst_n) begin
            assert ($onehot0(gnt));
            assert ((gnt == 4'b0000) || (gnt == (4'b0001 << {sel1, sel0})));
            for (int k = 0; k < 4; k++) begin
                assert (wait_q[k] <= WAIT_LIMIT);
            end
        end
    end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Scoreboard bench for rr_mux4_arbiter: a cycle model predicts grants and
// queues the data each owner should present on out one edge later.

module tb_rr_mux4_arbiter;

    localparam int DW   = 1;
    localparam int BMAX = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req;
    logic [DW-1:0] in0, in1, in2, in3;
    logic [3:0]    gnt;
    logic          sel1, sel0;
    logic [DW-1:0] out;
    logic          out_valid;

    rr_mux4_arbiter #(.DATA_W(DW), .BURST_MAX(BMAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .gnt       (gnt),
        .sel1      (sel1),
        .sel0      (sel0),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] sb[$];
    int            m_state, m_own, m_cnt, m_ptr;
    logic [3:0]    m_gnt;
    logic [1:0]    m_sel;
    logic          m_ov;
    bit            fix_data = 1'b0;

    task automatic model_reset();
        m_state = 0; m_own = 0; m_cnt = 0; m_ptr = 0;
        m_gnt = 4'b0000; m_sel = 2'b00; m_ov = 1'b0;
        sb.delete();
    endtask

    task automatic model_grant(input int k);
        m_state = 1; m_own = k; m_cnt = 0; m_ptr = (k + 1) % 4; m_sel = 2'(k);
    endtask

    // One rising edge of the reference behaviour, using pre-edge inputs.
    task automatic model_step();
        logic [DW-1:0] d[4];
        bit found;
        int k;
        int own0;
        d = '{in0, in1, in2, in3};
        if (m_state == 1) begin
            sb.push_back(d[m_own]);
            m_ov = 1'b1;
        end else begin
            m_ov = 1'b0;
        end
        found = 1'b0;
        own0  = m_own;
        if (m_state == 0) begin
            for (int i = 0; i < 4; i++) begin
                k = (m_ptr + i) % 4;
                if (!found && req[k]) begin found = 1'b1; model_grant(k); end
            end
        end else if (req[own0] && m_cnt < BMAX - 1) begin
            m_cnt++;
        end else begin
            for (int i = 1; i < 4; i++) begin
                k = (own0 + i) % 4;
                if (!found && req[k]) begin found = 1'b1; model_grant(k); end
            end
            if (!found) begin
                if (req[own0]) m_cnt = 0;
                else m_state = 0;
            end
        end
        m_gnt = (m_state == 1) ? 4'(1 << m_own) : 4'b0000;
    endtask

    task automatic tick();
        if (!fix_data) begin
            in0 = DW'($urandom); in1 = DW'($urandom);
            in2 = DW'($urandom); in3 = DW'($urandom);
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 4'b0000;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0;
        model_reset();
        #12;
        n_tests++;
        if ({gnt, sel1, sel0, out, out_valid} !== {4'b0000, 1'b0, 1'b0, {DW{1'b0}}, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got gnt=%b sel=%b%b out=%h v=%b, want all zero",
                     gnt, sel1, sel0, out, out_valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        fix_data = 1'b1;
        in0 = '0; in1 = '0; in2 = DW'(1); in3 = '0;
        apply_reset();
        req = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_tests++;
            if ({gnt, sel1, sel0, out_valid} !== {m_gnt, m_sel, m_ov}) begin
                n_fail++;
                $display("FAIL single_model c%0d: got %b/%b%b/%b want %b/%b/%b", c, gnt, sel1, sel0, out_valid, m_gnt, m_sel, m_ov);
            end
            if (out_valid === 1'b1) begin
                n_tests++;
                if (sb.size() == 0 || out !== sb[0]) begin
                    n_fail++;
                    $display("FAIL single_data c%0d: got %h want %h", c, out, (sb.size() != 0) ? sb[0] : 'x);
                end
                if (sb.size() != 0) void'(sb.pop_front());
            end
            n_tests++;
            if (gnt !== 4'b0100 || {sel1, sel0} !== 2'b10) begin
                n_fail++;
                $display("FAIL single_hold c%0d: got gnt=%b sel=%b%b want 0100/10", c, gnt, sel1, sel0);
            end
            if (c == 1) begin
                n_tests++;
                if (out !== DW'(1) || out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_out: got out=%h v=%b want 1/1", out, out_valid);
                end
            end
        end
        fix_data = 1'b0;
    endtask

    task automatic test_round_robin();
        int own;
        apply_reset();
        req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            tick();
            own = (c / 4) % 4;
            n_tests++;
            if (gnt !== 4'(1 << own) || {sel1, sel0} !== 2'(own)) begin
                n_fail++;
                $display("FAIL rr_order c%0d: got gnt=%b sel=%b%b want owner %0d", c, gnt, sel1, sel0, own);
            end
            if (out_valid === 1'b1) begin
                n_tests++;
                if (sb.size() == 0 || out !== sb[0]) begin
                    n_fail++;
                    $display("FAIL rr_data c%0d: got %h want %h", c, out, (sb.size() != 0) ? sb[0] : 'x);
                end
                if (sb.size() != 0) void'(sb.pop_front());
            end
        end
    endtask

    task automatic test_early_drop();
        apply_reset();
        req = 4'b1010;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) req = 4'b1000;
            tick();
            n_tests++;
            if ({gnt, sel1, sel0} !== ((c < 2) ? 6'b0010_01 : 6'b1000_11)) begin
                n_fail++;
                $display("FAIL early_drop c%0d: got gnt=%b sel=%b%b", c, gnt, sel1, sel0);
            end
            n_tests++;
            if ({gnt, sel1, sel0, out_valid} !== {m_gnt, m_sel, m_ov}) begin
                n_fail++;
                $display("FAIL early_model c%0d: got %b/%b%b/%b want %b/%b/%b", c, gnt, sel1, sel0, out_valid, m_gnt, m_sel, m_ov);
            end
            if (out_valid === 1'b1) begin
                n_tests++;
                if (sb.size() == 0 || out !== sb[0]) begin
                    n_fail++;
                    $display("FAIL early_data c%0d: got %h want %h", c, out, (sb.size() != 0) ? sb[0] : 'x);
                end
                if (sb.size() != 0) void'(sb.pop_front());
            end
        end
    endtask

    task automatic test_idle_return();
        apply_reset();
        req = 4'b0001;
        tick();
        tick();
        req = 4'b0000;
        tick();
        n_tests++;
        if (gnt !== 4'b0000 || {sel1, sel0} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_gnt: got gnt=%b sel=%b%b want 0000/00", gnt, sel1, sel0);
        end
        if (out_valid === 1'b1 && sb.size() != 0) void'(sb.pop_front());
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || {sel1, sel0} !== 2'b00 || gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_valid: got v=%b sel=%b%b gnt=%b want 0/00/0000", out_valid, sel1, sel0, gnt);
        end
        req = 4'b0011;
        tick();
        n_tests++;
        if (gnt !== 4'b0010 || {sel1, sel0} !== 2'b01) begin
            n_fail++;
            $display("FAIL idle_pointer: got gnt=%b sel=%b%b want 0010/01", gnt, sel1, sel0);
        end
        sb.delete();
    endtask

    task automatic test_async_reset();
        apply_reset();
        req = 4'b0010;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({gnt, sel1, sel0, out, out_valid} !== {4'b0000, 2'b00, {DW{1'b0}}, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got gnt=%b sel=%b%b out=%h v=%b want zeros", gnt, sel1, sel0, out, out_valid);
        end
        model_reset();
        @(negedge clk);
        req   = 4'b1111;
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (gnt !== 4'b0001 || {sel1, sel0} !== 2'b00) begin
            n_fail++;
            $display("FAIL async_first_grant: got gnt=%b sel=%b%b want 0001/00", gnt, sel1, sel0);
        end
    endtask

    task automatic test_no_preempt();
        logic [3:0] want;
        for (int v = 0; v < 2; v++) begin
            apply_reset();
            req = 4'b0100;
            for (int c = 0; c < 6; c++) begin
                if (c == 1) req = (v == 1) ? 4'b1101 : 4'b0101;
                tick();
                want = (c <= 3) ? 4'b0100 : ((v == 1) ? 4'b1000 : 4'b0001);
                n_tests++;
                if (gnt !== want) begin
                    n_fail++;
                    $display("FAIL no_preempt v%0d c%0d: got gnt=%b want %b", v, c, gnt, want);
                end
                if (out_valid === 1'b1) begin
                    n_tests++;
                    if (sb.size() == 0 || out !== sb[0]) begin
                        n_fail++;
                        $display("FAIL preempt_data v%0d c%0d: got %h want %h", v, c, out, (sb.size() != 0) ? sb[0] : 'x);
                    end
                    if (sb.size() != 0) void'(sb.pop_front());
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            tick();
            n_tests++;
            if ({gnt, sel1, sel0, out_valid} !== {m_gnt, m_sel, m_ov}) begin
                n_fail++;
                $display("FAIL b2b_model c%0d: got %b/%b%b/%b want %b/%b/%b", c, gnt, sel1, sel0, out_valid, m_gnt, m_sel, m_ov);
            end
            if (out_valid === 1'b1) begin
                n_tests++;
                if (sb.size() == 0 || out !== sb[0]) begin
                    n_fail++;
                    $display("FAIL b2b_data c%0d: got %h want %h", c, out, (sb.size() != 0) ? sb[0] : 'x);
                end
                if (sb.size() != 0) void'(sb.pop_front());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_early_drop();
        test_idle_return();
        test_async_reset();
        test_no_preempt();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
